// File: rtl/parity_pkg.sv
// Shared helpers for the pipelined parity tree: sizing and register placement.
package parity_pkg;

  // Ceiling log2 for elaboration-time sizing (n >= 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Width after zero-padding to the next power of two.
  function automatic int pad_w(input int data_w);
    return 1 << clog2(data_w);
  endfunction

  // Tree level whose output is captured by register stage k (1-based).
  // Computed as ceil(k*L/S), so the last stage always lands on level L.
  function automatic int stage_level(input int k, input int l, input int s);
    return (k * l + s - 1) / s;
  endfunction

  // True when some register stage captures the output of tree level lvl.
  function automatic bit is_reg_level(input int lvl, input int l, input int s);
    for (int k = 1; k <= s; k++)
      if (stage_level(k, l, s) == lvl) return 1'b1;
    return 1'b0;
  endfunction

  // Bit offset of tree level lvl inside the flattened tree vector.
  // Level widths are pad, pad/2, ... so the offset is 2*pad - 2*(pad>>lvl).
  function automatic int lvl_off(input int lvl, input int pad);
    return 2 * pad - 2 * (pad >> lvl);
  endfunction

endpackage

// File: rtl/parity_xor_level.sv
// One XOR-tree level: folds IN_W bits into IN_W/2 pairwise XORs,
// optionally registered.
module parity_xor_level #(
  parameter int IN_W = 2,
  parameter int REG  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   i_d,
  output logic [IN_W/2-1:0] o_q
);

  logic [IN_W/2-1:0] w_x;

  // Pairwise fold of adjacent bits.
  always_comb begin
    w_x = '0;
    for (int i = 0; i < IN_W / 2; i++) w_x[i] = i_d[2*i] ^ i_d[2*i+1];
  end

  if (REG != 0) begin : g_reg
    logic [IN_W/2-1:0] r_q;
    // Pipeline register for this level; cleared by reset.
    always_ff @(posedge clk) begin
      if (!rst_n) r_q <= '0;
      else        r_q <= w_x;
    end
    assign o_q = r_q;
  end else begin : g_comb
    logic w_unused;
    assign w_unused = clk ^ rst_n;
    assign o_q = w_x;
  end

endmodule

// File: rtl/parity_generator.sv
// Pipelined parity generator: zero-padded XOR tree with configurable
// register placement, a valid delay line and final polarity inversion.
module parity_generator
  import parity_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ODD_PARITY  = 0,
  parameter int PIPE_STAGES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a,
  output logic              out_valid,
  output logic              parity
);

  localparam int   L      = clog2(DATA_W);
  localparam int   PAD_W  = pad_w(DATA_W);
  localparam int   TOP    = lvl_off(L, PAD_W);
  localparam int   TREE_W = TOP + 1;
  localparam logic INV    = (ODD_PARITY != 0);

  if (DATA_W < 2) begin : g_bad_width
    $error("parity_generator: DATA_W must be >= 2");
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > L) begin : g_bad_stages
    $error("parity_generator: PIPE_STAGES must be in 1..clog2(DATA_W)");
  end

  // All tree levels flattened: level 0 (padded word) in the low bits,
  // the single root bit at TOP.
  logic [TREE_W-1:0] w_tree;
  logic [PAD_W-1:0]  w_pad;

  // Zero-pad the input word up to a power of two.
  always_comb begin
    w_pad = '0;
    w_pad[DATA_W-1:0] = a;
  end
  assign w_tree[PAD_W-1:0] = w_pad;

  // The root level is left combinational here; the final stage register
  // below captures it together with the polarity inversion so that reset
  // yields parity=0 even for odd parity.
  for (genvar j = 1; j <= L; j++) begin : g_lvl
    parity_xor_level #(
      .IN_W (PAD_W >> (j - 1)),
      .REG  ((is_reg_level(j, L, PIPE_STAGES) && j != L) ? 1 : 0)
    ) u_lvl (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (w_tree[lvl_off(j - 1, PAD_W) +: (PAD_W >> (j - 1))]),
      .o_q   (w_tree[lvl_off(j, PAD_W) +: (PAD_W >> j)])
    );
  end

  logic                   r_parity;
  logic [PIPE_STAGES-1:0] r_vld_pipe;

  // Final stage: register the root bit with polarity applied.
  always_ff @(posedge clk) begin
    if (!rst_n) r_parity <= 1'b0;
    else        r_parity <= w_tree[TOP] ^ INV;
  end

  // Valid delay line, same depth as the data path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= in_valid;
      for (int i = 1; i < PIPE_STAGES; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
    end
  end

  assign parity    = r_parity;
  assign out_valid = r_vld_pipe[PIPE_STAGES-1];

endmodule

// File: tb/tb_parity_generator.sv
// Directed bench for parity_generator: four instances with different
// parameter sets share clock, reset, valid and data.
module tb_parity_generator;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a;

  logic ov0, p0, ovo, po, ov4, p4, ov13, p13;
  int   checks;
  int   errors;

  parity_generator #(.DATA_W(16), .ODD_PARITY(0), .PIPE_STAGES(1)) u_def (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a),
    .out_valid(ov0), .parity(p0));

  parity_generator #(.DATA_W(16), .ODD_PARITY(1), .PIPE_STAGES(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a),
    .out_valid(ovo), .parity(po));

  parity_generator #(.DATA_W(16), .ODD_PARITY(0), .PIPE_STAGES(4)) u_p4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a),
    .out_valid(ov4), .parity(p4));

  parity_generator #(.DATA_W(13), .ODD_PARITY(0), .PIPE_STAGES(2)) u_w13 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a[12:0]),
    .out_valid(ov13), .parity(p13));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present inputs, take one rising edge, settle 1 time unit.
  task automatic cyc(input logic v, input logic [15:0] d);
    in_valid = v;
    a        = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  logic [15:0] vec [5];
  logic        exp_even [5];
  logic [15:0] v;

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0;
    vec[0] = 16'h0000; exp_even[0] = 1'b0;
    vec[1] = 16'h0001; exp_even[1] = 1'b1;
    vec[2] = 16'hFFFF; exp_even[2] = 1'b0;
    vec[3] = 16'h8001; exp_even[3] = 1'b0;
    vec[4] = 16'h7FFF; exp_even[4] = 1'b1;

    // Reset state, odd parity included
    cyc(1'b1, 16'h0001);
    cyc(1'b1, 16'h0001);
    chk("rst_ov_def", ov0, 1'b0);
    chk("rst_p_def",  p0,  1'b0);
    chk("rst_p_odd",  po,  1'b0);
    chk("rst_ov_p4",  ov4, 1'b0);
    chk("rst_p_p4",   p4,  1'b0);
    chk("rst_ov_w13", ov13, 1'b0);
    rst_n = 1'b1;

    // Directed vectors, 1-cycle latency
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, vec[i]);
      chk("vec_ov",  ov0, 1'b1);
      chk("vec_p",   p0,  exp_even[i]);
      chk("vec_odd", po,  ~exp_even[i]);
    end
    cyc(1'b1, 16'h0003);
    chk("odd_0003", po, 1'b1);
    chk("even_0003", p0, 1'b0);
    cyc(1'b1, 16'h0007);
    chk("odd_0007", po, 1'b0);
    chk("even_0007", p0, 1'b1);
    cyc(1'b0, 16'h0000);
    chk("idle_ov", ov0, 1'b0);
    chk("odd_0000", po, 1'b1);

    // PIPE_STAGES=4 latency
    for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0000);
    cyc(1'b1, 16'h0001);
    chk("p4_lat0_ov", ov4, 1'b0);
    cyc(1'b0, 16'h0000);
    chk("p4_lat1_ov", ov4, 1'b0);
    cyc(1'b0, 16'h0000);
    chk("p4_lat2_ov", ov4, 1'b0);
    cyc(1'b0, 16'h0000);
    chk("p4_lat3_ov", ov4, 1'b1);
    chk("p4_lat3_p",  p4,  1'b1);
    cyc(1'b0, 16'h0000);
    chk("p4_lat4_ov", ov4, 1'b0);

    // PIPE_STAGES=4 back-to-back
    cyc(1'b1, 16'h0001);
    cyc(1'b1, 16'h0003);
    cyc(1'b0, 16'h0000);
    cyc(1'b0, 16'h0000);
    chk("p4_b2b0_ov", ov4, 1'b1);
    chk("p4_b2b0_p",  p4,  1'b1);
    cyc(1'b0, 16'h0000);
    chk("p4_b2b1_ov", ov4, 1'b1);
    chk("p4_b2b1_p",  p4,  1'b0);
    cyc(1'b0, 16'h0000);
    chk("p4_b2b2_ov", ov4, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0000);

    // DATA_W=13, PIPE_STAGES=2: zero padding and valid gaps
    cyc(1'b1, 16'h1FFF);
    chk("w13_s0_ov", ov13, 1'b0);
    cyc(1'b0, 16'h0000);
    chk("w13_1fff_ov", ov13, 1'b1);
    chk("w13_1fff_p",  p13,  1'b1);
    cyc(1'b1, 16'h1000);
    chk("w13_gap_ov", ov13, 1'b0);
    chk("w13_gap_p",  p13,  1'b0);
    cyc(1'b0, 16'h0000);
    chk("w13_1000_ov", ov13, 1'b1);
    chk("w13_1000_p",  p13,  1'b1);
    cyc(1'b0, 16'h0000);
    chk("w13_end_ov", ov13, 1'b0);

    // Reset mid-stream discards in-flight words
    cyc(1'b1, 16'h0001);
    chk("mid_pre_p", p0, 1'b1);
    rst_n = 1'b0;
    cyc(1'b0, 16'h0000);
    chk("mid_rst_ov", ov0, 1'b0);
    chk("mid_rst_p",  p0,  1'b0);
    chk("mid_rst_odd", po, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 16'h0000);
      chk("mid_p4_ov", ov4, 1'b0);
      chk("mid_p4_p",  p4,  1'b0);
    end

    // Exhaustive sweep on the default and odd instances
    for (int i = 0; i < 65536; i++) begin
      v = 16'(i);
      cyc(1'b1, v);
      chk("sweep_p",   p0, ^v);
      chk("sweep_odd", po, ~^v);
    end
    chk("sweep_ov", ov0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
